// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device transmitter for the PS/2 link. Sends one command byte
// (for example 0xF4, 0xED, 0xFF) to a keyboard or mouse and checks the
// device's acknowledge bit.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   ps2clk_ext   PS/2 clock pin as sensed (asynchronous)
//   ps2data_ext  PS/2 data pin as sensed (asynchronous)
//   data[7:0]    byte to send, captured on the cycle send=1
//   send         one-cycle start strobe, ignored while busy
//   ps2clk_low   1 = pull the clock pin low (open-drain enable)
//   ps2data_low  1 = pull the data pin low (open-drain enable)
//   busy         transfer in progress; the receiver ignores the lines
//   done         one-cycle pulse: transfer ended with acknowledge
//   error        one-cycle pulse: transfer ended by timeout or no acknowledge
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int START_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 560000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_ext,
    input  logic       ps2data_ext,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ps2clk_low,
    output logic       ps2data_low,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // One shared cycle counter serves the inhibit, start and timeout phases.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES)
                           ? ((TIMEOUT_CYCLES > START_CYCLES) ? TIMEOUT_CYCLES : START_CYCLES)
                           : ((INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES);
    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int FILT_W = $clog2(FILTER_LEN + 1);

    localparam logic [CNT_W-1:0]  INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(FILTER_LEN - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_XFER     = 3'd3;
    localparam logic [2:0] S_WAITIDLE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        data_q, data_d;
    logic              parity_q, parity_d;
    logic              ack_q, ack_d;
    logic              clk_low_q, clk_low_d;
    logic              dat_low_q, dat_low_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              clk_m_q, clk_s_q, dat_m_q, dat_s_q;
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall;
    logic              leave_start;
    logic [3:0]        nbit;

    assign leave_start = (state_q == S_START) && (cnt_q == START_LAST);

    // Clock-line stability filter. The filtered level only flips after
    // FILTER_LEN consecutive synchronized samples disagree with it. When the
    // host releases the clock at the end of START the level is forced high,
    // so the host's own low drive never shows up as a device clock edge.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_s_q == filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            filt_d     = clk_s_q;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fall = filt_q & ~filt_d;
        if (leave_start) begin
            filt_d     = 1'b1;
            filt_cnt_d = '0;
        end
    end

    // Transfer sequencer: inhibit, start bit, eleven device clocks, then wait
    // for the bus to go idle before reporting the acknowledge result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        parity_d  = parity_q;
        ack_d     = ack_q;
        clk_low_d = clk_low_q;
        dat_low_d = dat_low_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        nbit      = bit_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (send) begin
                    data_d    = data;
                    parity_d  = ~^data;
                    bit_d     = 4'd0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    clk_low_d = 1'b1;
                    dat_low_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    dat_low_d = 1'b1;
                    state_d   = S_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                if (leave_start) begin
                    cnt_d     = '0;
                    clk_low_d = 1'b0;
                    state_d   = S_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_XFER, S_WAITIDLE: begin
                // A timeout overrides any clock edge seen in the same cycle.
                if (cnt_q == TO_LAST) begin
                    cnt_d     = '0;
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b0;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == S_XFER) begin
                        if (fall) begin
                            bit_d = nbit;
                            case (nbit)
                                4'd9:    dat_low_d = ~parity_q;
                                4'd10:   dat_low_d = 1'b0;
                                4'd11: begin
                                    ack_d   = ~dat_s_q;
                                    state_d = S_WAITIDLE;
                                end
                                default: dat_low_d = ~data_q[3'(nbit - 4'd1)];
                            endcase
                        end
                    end else if (filt_q && dat_s_q) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = ack_q;
                        error_d = ~ack_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; the pins reset to their released (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd0;
            data_q     <= 8'd0;
            parity_q   <= 1'b0;
            ack_q      <= 1'b0;
            clk_low_q  <= 1'b0;
            dat_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_m_q    <= 1'b1;
            clk_s_q    <= 1'b1;
            dat_m_q    <= 1'b1;
            dat_s_q    <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            ack_q      <= ack_d;
            clk_low_q  <= clk_low_d;
            dat_low_q  <= dat_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_m_q    <= ps2clk_ext;
            clk_s_q    <= clk_m_q;
            dat_m_q    <= ps2data_ext;
            dat_s_q    <= dat_m_q;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign ps2clk_low  = clk_low_q;
    assign ps2data_low = dat_low_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Bench for ps2_host_tx. A behavioural PS/2 device drives the clock pin,
// records the bits the host puts on the data line and optionally
// acknowledges. Expected frames come from the protocol rules: eight data bits
// LSB first, an odd-parity bit, a stop bit of 1.
module tb_ps2_host_tx;

    localparam int INHIBIT = 40;
    localparam int STARTC  = 16;
    localparam int TIMEOUT = 3000;
    localparam int HALF    = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       send;
    logic       devClk;
    logic       devData;
    logic       ps2clkLow, ps2dataLow, busy, done, error;
    wire        ps2clkExt  = ~ps2clkLow & devClk;
    wire        ps2dataExt = ~ps2dataLow & devData;

    int checkCount = 0;
    int errorCount = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .START_CYCLES  (STARTC),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_LEN    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2clk_ext (ps2clkExt),
        .ps2data_ext(ps2dataExt),
        .data       (data),
        .send       (send),
        .ps2clk_low (ps2clkLow),
        .ps2data_low(ps2dataLow),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Frame the device should see: {stop, parity, data}, data bit 0 first.
    function automatic logic [9:0] expFrame(input logic [7:0] d);
        int ones;
        logic par;
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(d[k]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Strobe send, optionally re-strobe with 0xFF while busy, and measure the
    // inhibit and start phases. Returns at the first cycle after clock release.
    task automatic applyStimulus(input logic [7:0] d, input bit resend);
        int inh;
        int stc;
        @(negedge clk);
        data = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        data = 8'($urandom);
        checkOutput("busy_after_send", busy, 1);
        inh = 0;
        while (ps2clkLow && !ps2dataLow && inh < 10000) begin
            inh++;
            if (resend && inh == 3) begin
                data = 8'hFF;
                send = 1'b1;
            end else begin
                send = 1'b0;
            end
            @(negedge clk);
        end
        send = 1'b0;
        checkOutput("inhibit_cycles", inh, INHIBIT);
        stc = 0;
        while (ps2clkLow && ps2dataLow && stc < 10000) begin
            stc++;
            @(negedge clk);
        end
        checkOutput("start_cycles", stc, STARTC);
        checkOutput("released_clk_start_bit", {ps2clkLow, ps2dataLow, busy}, 3'b011);
    endtask

    // Device side: nPulses clock pulses, ack on pulse 11, optional 3-cycle
    // low glitch during the high phase of pulse glitchAt.
    task automatic deviceClock(input int nPulses, input bit ack, input int glitchAt,
                               output logic [9:0] bits);
        bits = '0;
        repeat (20) @(negedge clk);
        checkOutput("start_bit_on_line", ps2dataExt, 0);
        for (int i = 1; i <= nPulses; i++) begin
            if (i == 11) begin
                devData = ack ? 1'b0 : 1'b1;
                repeat (HALF / 2) @(negedge clk);
            end
            devClk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i <= 10) bits[i-1] = ps2dataExt;
            devClk = 1'b1;
            if (i == glitchAt) begin
                repeat (10) @(negedge clk);
                devClk = 1'b0;
                repeat (3) @(negedge clk);
                devClk = 1'b1;
                repeat (HALF - 13) @(negedge clk);
            end else if (i == 11) begin
                repeat (3) @(negedge clk);
                devData = 1'b1;
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    // Wait (bounded) for the end pulse and check its kind and the idle lines.
    task automatic finishTransfer(input bit expAck);
        int k;
        k = 0;
        while (!(done || error) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("end_pulse_seen", done | error, 1);
        checkOutput("done_pulse", done, expAck);
        checkOutput("error_pulse", error, !expAck);
        checkOutput("idle_outputs", {ps2clkLow, ps2dataLow, busy}, 3'b000);
        @(negedge clk);
        checkOutput("pulse_one_cycle", {done, error}, 2'b00);
    endtask

    task automatic fullTransfer(input logic [7:0] d, input bit ack, input int glitchAt,
                                input bit resend, output logic [9:0] bits);
        applyStimulus(d, resend);
        deviceClock(11, ack, glitchAt, bits);
        checkOutput("frame_bits", bits, expFrame(d));
        finishTransfer(ack);
    endtask

    initial begin
        logic [9:0] bits;
        logic [7:0] rd;
        bit         rAck;
        int         t;

        rst     = 1'b1;
        data    = 8'h00;
        send    = 1'b0;
        devClk  = 1'b1;
        devData = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {ps2clkLow, ps2dataLow, busy, done, error}, 5'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] send 0xF4 with ack");
        fullTransfer(8'hF4, 1'b1, 0, 1'b0, bits);
        checkOutput("f4_literal_bits", bits, 10'b10_1111_0100);

        $display("[TB] send 0xED then 0x00");
        fullTransfer(8'hED, 1'b1, 0, 1'b0, bits);
        checkOutput("ed_parity", bits[8], 1);
        fullTransfer(8'h00, 1'b1, 0, 1'b0, bits);
        checkOutput("00_parity", bits[8], 1);

        $display("[TB] device withholds ack");
        fullTransfer(8'h3C, 1'b0, 0, 1'b0, bits);

        $display("[TB] timeout with no device clocking");
        applyStimulus(8'hA5, 1'b0);
        t = 0;
        while (!error && t < TIMEOUT + 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput("timeout_cycles", t, TIMEOUT);
        checkOutput("timeout_outputs", {ps2clkLow, ps2dataLow, busy, done}, 4'b0);
        @(negedge clk);
        checkOutput("timeout_pulse_one_cycle", error, 0);

        $display("[TB] send re-strobed while busy");
        fullTransfer(8'h12, 1'b1, 0, 1'b1, bits);

        $display("[TB] reset in the middle of a transfer");
        applyStimulus(8'h5A, 1'b0);
        deviceClock(4, 1'b1, 0, bits);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_outputs", {ps2clkLow, ps2dataLow, busy, done, error}, 5'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midreset_no_pulse", {done, error, busy}, 3'b000);
        fullTransfer(8'hF4, 1'b1, 0, 1'b0, bits);

        $display("[TB] 3-cycle glitch on the clock line");
        fullTransfer(8'hC9, 1'b1, 4, 1'b0, bits);

        $display("[TB] random bytes and ack choices");
        for (int r = 0; r < 4; r++) begin
            rd   = 8'($urandom);
            rAck = 1'($urandom_range(0, 1));
            fullTransfer(rd, rAck, 0, 1'b0, bits);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
